// File: rtl/audio_pkg.sv
// Shared audio definitions: default sample width and rate, the stereo sample
// record handed to the DAC, and the pacer state encoding.
package audio_pkg;

  localparam int AUDIO_WIDTH      = 4;
  // 656 clk cycles per sample gives 32768 Hz from the system clock.
  localparam int AUDIO_SAMPLE_DIV = 656;

  typedef struct packed {
    logic [AUDIO_WIDTH-1:0] left;
    logic [AUDIO_WIDTH-1:0] right;
  } stereo_t;

  typedef enum logic {
    ST_PREFILL = 1'b0,
    ST_PLAY    = 1'b1
  } pacer_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO for stereo sample pairs. The level counter is kept
// separately from the wrapping pointers so full and empty are exact.
module sample_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rd_data,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [LW-1:0] level_reg;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level_reg == LW'(DEPTH));
  assign empty   = (level_reg == '0);
  assign push_ok = push && !full;
  // Gated on registered empty, so a same-cycle push into an empty FIFO is not poppable.
  assign pop_ok  = pop && !empty;
  assign level   = level_reg;
  assign rd_data = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/audio_sample_pacer.sv
// Buffers stereo samples and releases exactly one pair per sample period to the DAC.
// Build option AUDIO_PACER_UNDERRUN_ZERO_EN: outputs go silent on underrun instead of holding.
module audio_sample_pacer
  import audio_pkg::*;
#(
  parameter int WIDTH      = AUDIO_WIDTH,
  parameter int DEPTH      = 16,
  parameter int SAMPLE_DIV = AUDIO_SAMPLE_DIV,
  parameter int PREFILL    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         in_left,
  input  logic [WIDTH-1:0]         in_right,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         left_out,
  output logic [WIDTH-1:0]         right_out,
  output logic                     sample_tick,
  output logic                     playing,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               underrun_cnt
);

  localparam int LW   = $clog2(DEPTH) + 1;
  localparam int DIVW = $clog2(SAMPLE_DIV);
  localparam logic [LW-1:0]   PREFILL_LVL = LW'(PREFILL);
  localparam logic [DIVW-1:0] DIV_LAST    = DIVW'(SAMPLE_DIV - 1);

  pacer_state_t      state_reg;
  logic [DIVW-1:0]   div_reg;
  logic [WIDTH-1:0]  left_reg;
  logic [WIDTH-1:0]  right_reg;
  logic              sample_tick_reg;
  logic [7:0]        underrun_cnt_reg;
  logic              div_tick;
  logic              pop_req;
  logic              fifo_full;
  logic              fifo_empty;
  logic [2*WIDTH-1:0] fifo_head;

  assign div_tick = (div_reg == DIV_LAST);
  assign pop_req  = div_tick && (state_reg == ST_PLAY) && !fifo_empty;

  sample_fifo #(
    .DW    (2 * WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (in_valid),
    .pop     (pop_req),
    .wr_data ({in_left, in_right}),
    .rd_data (fifo_head),
    .level   (level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Free-running in every state so output updates stay phase-locked to the DAC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg <= '0;
    end else if (div_tick) begin
      div_reg <= '0;
    end else begin
      div_reg <= div_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_PREFILL;
      left_reg         <= '0;
      right_reg        <= '0;
      sample_tick_reg  <= 1'b0;
      underrun_cnt_reg <= '0;
    end else begin
      sample_tick_reg <= 1'b0;
      if (div_tick) begin
        case (state_reg)
          ST_PREFILL: begin
            if (level >= PREFILL_LVL) begin
              state_reg <= ST_PLAY;
            end
          end
          ST_PLAY: begin
            sample_tick_reg <= 1'b1;
            if (!fifo_empty) begin
              {left_reg, right_reg} <= fifo_head;
            end else begin
              if (underrun_cnt_reg != 8'hFF) begin
                underrun_cnt_reg <= underrun_cnt_reg + 8'd1;
              end
`ifdef AUDIO_PACER_UNDERRUN_ZERO_EN
              left_reg  <= '0;
              right_reg <= '0;
`endif
              state_reg <= ST_PREFILL;
            end
          end
          default: state_reg <= ST_PREFILL;
        endcase
      end
    end
  end

  assign in_ready     = !fifo_full;
  assign left_out     = left_reg;
  assign right_out    = right_reg;
  assign sample_tick  = sample_tick_reg;
  assign playing      = (state_reg == ST_PLAY);
  assign underrun_cnt = underrun_cnt_reg;

endmodule
